// File: rtl/data_ram_slave_pkg.sv
// -----------------------------------------------------------------------------
// data_ram_slave_pkg
// Shared definitions for the data RAM slave:
//   - bus widths
//   - the default register-block base and the register offsets inside it
//   - STATUS bit positions
//   - the address-select enum and the address decode helper
// -----------------------------------------------------------------------------
package data_ram_slave_pkg;

    // Bus widths
    localparam int XLEN      = 32;
    localparam int BYTE_OFFS = 2;  // byte-offset bits in a word address

    // Address map
    localparam logic [XLEN-1:0] MMIO_BASE_DEFAULT = 32'h1000_0000;
    localparam logic [XLEN-1:0] OFF_CYCLE         = 32'h0000_0000;
    localparam logic [XLEN-1:0] OFF_CMP           = 32'h0000_0004;
    localparam logic [XLEN-1:0] OFF_STATUS        = 32'h0000_0008;
    localparam logic [XLEN-1:0] OFF_ACCESS        = 32'h0000_000C;

    // STATUS bit positions
    localparam int ST_MATCH    = 0;
    localparam int ST_BADADDR  = 1;
    localparam int ST_MISALIGN = 2;
    localparam int ST_W        = 3;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_CYCLE,
        SEL_CMP,
        SEL_STATUS,
        SEL_ACCESS
    } sel_e;

    // Decode on the word address. The byte offset is ignored here, so a
    // misaligned access still decodes to its target. The misaligned check is
    // kept separate from the decode.
    function automatic sel_e decode_addr(input logic [XLEN-1:0] addr,
                                         input logic [XLEN-1:0] base,
                                         input int unsigned     depth_log2);
        logic [XLEN-1:0] wa;
        sel_e            sel;
        wa  = {addr[XLEN-1:BYTE_OFFS], {BYTE_OFFS{1'b0}}};
        sel = SEL_NONE;
        if ((wa >> (depth_log2 + BYTE_OFFS)) == '0) sel = SEL_RAM;
        else if (wa == base + OFF_CYCLE)            sel = SEL_CYCLE;
        else if (wa == base + OFF_CMP)              sel = SEL_CMP;
        else if (wa == base + OFF_STATUS)           sel = SEL_STATUS;
        else if (wa == base + OFF_ACCESS)           sel = SEL_ACCESS;
        return sel;
    endfunction

endpackage

// File: rtl/data_ram_slave_if.sv
// -----------------------------------------------------------------------------
// data_ram_slave_if
// Memory-stage access bus between the core and the data RAM slave.
//   ce     : access enable
//   we     : 1 = write, 0 = read (only meaningful when ce = 1)
//   addr   : byte address
//   data_i : write data (master to slave)
//   data_o : read data (slave to master), returned in the same cycle
// -----------------------------------------------------------------------------
interface data_ram_slave_if;
    import data_ram_slave_pkg::*;

    logic            ce;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data_i;
    logic [XLEN-1:0] data_o;

    modport master (output ce, we, addr, data_i, input  data_o);
    modport slave  (input  ce, we, addr, data_i, output data_o);
endinterface

// File: rtl/data_ram_slave_dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Word storage with 2^DEPTH_LOG2 entries.
//   - One asynchronous (combinational) read port.
//   - One synchronous write port.
// The contents have no reset.
// Ports:
//   clk        : write clock
//   wr_en      : write strobe
//   wr_idx     : word index for the write
//   wr_data    : write data
//   rd_idx     : word index for the read
//   rd_data    : read data
// -----------------------------------------------------------------------------
module dmem_array
    import data_ram_slave_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [XLEN-1:0]       wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [XLEN-1:0]       rd_data
);

    logic [XLEN-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/data_ram_slave.sv
// -----------------------------------------------------------------------------
// data_ram_slave
// Data RAM plus a small register block, for the core's memory stage.
// Registers:
//   CYCLE  : free-running cycle counter; writes to it are ignored
//   CMP    : compare value for CYCLE
//   STATUS : sticky write-1-to-clear flags (match, bad address, misaligned)
//   ACCESS : saturating count of RAM-decoded accesses
// Reads return data combinationally in the same cycle.
// Ports:
//   clk : clock
//   rst : synchronous reset, active high
//   bus : data_ram_slave_if.slave (ce, we, addr, data_i, data_o)
// -----------------------------------------------------------------------------
module data_ram_slave
    import data_ram_slave_pkg::*;
#(
    parameter int              DEPTH_LOG2 = 10,
    parameter logic [XLEN-1:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    data_ram_slave_if.slave  bus
);

    logic [XLEN-1:0] cycle_q,  cycle_d;
    logic [XLEN-1:0] cmp_q,    cmp_d;
    logic [ST_W-1:0] status_q, status_d;
    logic [XLEN-1:0] access_q, access_d;

    sel_e            sel;
    logic            misaligned;
    logic            live;
    logic            acc_ok;
    logic            reg_we;
    logic            ram_we;
    logic [ST_W-1:0] st_set;
    logic [ST_W-1:0] st_clr;
    logic [XLEN-1:0] ram_rdata;
    logic [XLEN-1:0] rdata;

    logic [DEPTH_LOG2-1:0] ram_idx;

    // Decode
    assign sel        = decode_addr(bus.addr, MMIO_BASE, DEPTH_LOG2);
    assign misaligned = (bus.addr[BYTE_OFFS-1:0] != '0);
    assign live       = bus.ce & ~rst;
    // An access takes effect only when it is aligned and hits something.
    assign acc_ok     = live & ~misaligned & (sel != SEL_NONE);
    assign reg_we     = acc_ok & bus.we;
    assign ram_we     = reg_we & (sel == SEL_RAM);
    assign ram_idx    = bus.addr[DEPTH_LOG2+BYTE_OFFS-1:BYTE_OFFS];

    dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_dmem (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_idx  (ram_idx),
        .wr_data (bus.data_i),
        .rd_idx  (ram_idx),
        .rd_data (ram_rdata)
    );

    // Next-state logic for the registers
    always_comb begin
        cycle_d  = cycle_q + 32'd1;
        cmp_d    = cmp_q;
        access_d = access_q;
        st_set   = '0;
        st_clr   = '0;

        if (reg_we && sel == SEL_CMP)    cmp_d  = bus.data_i;
        if (reg_we && sel == SEL_STATUS) st_clr = bus.data_i[ST_W-1:0];

        st_set[ST_MATCH]    = (cycle_q == cmp_q);
        st_set[ST_BADADDR]  = live & (sel == SEL_NONE);
        st_set[ST_MISALIGN] = live & misaligned;

        // Set is applied after the clear, so a same-cycle event survives a
        // W1C of the same bit.
        status_d = (status_q & ~st_clr) | st_set;

        if (acc_ok && sel == SEL_RAM && access_q != '1) access_d = access_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q  <= '0;
            cmp_q    <= '0;
            status_q <= '0;
            access_q <= '0;
        end else begin
            cycle_q  <= cycle_d;
            cmp_q    <= cmp_d;
            status_q <= status_d;
            access_q <= access_d;
        end
    end

    // Read mux: only reads that take effect return data; everything else is 0.
    always_comb begin
        rdata = '0;
        if (acc_ok && !bus.we) begin
            unique case (sel)
                SEL_RAM:    rdata = ram_rdata;
                SEL_CYCLE:  rdata = cycle_q;
                SEL_CMP:    rdata = cmp_q;
                SEL_STATUS: rdata = {{(XLEN-ST_W){1'b0}}, status_q};
                SEL_ACCESS: rdata = access_q;
                default:    rdata = '0;
            endcase
        end
    end

    assign bus.data_o = rdata;

endmodule

// File: tb/tb_data_ram_slave.sv
module tb_data_ram_slave;
    import data_ram_slave_pkg::*;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [31:0] A_CYC = BASE + 32'h0;
    localparam logic [31:0] A_CMP = BASE + 32'h4;
    localparam logic [31:0] A_ST  = BASE + 32'h8;
    localparam logic [31:0] A_ACC = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] rd;
    int          total = 0;
    int          bad   = 0;

    data_ram_slave_if bus ();

    data_ram_slave #(.DEPTH_LOG2(10), .MMIO_BASE(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // One bus cycle: drive at the falling edge, sample data_o shortly after.
    task automatic cyc(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.ce = c; bus.we = w; bus.addr = a; bus.data_i = d;
        #1 rd = bus.data_o;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b1, a, d);
    endtask

    task automatic rdw(input logic [31:0] a);
        cyc(1'b1, 1'b0, a, 32'h0);
    endtask

    // Returns just after the last reset edge; the next cyc() runs in the first
    // cycle after reset, where CYCLE reads 0.
    task automatic hard_reset();
        @(negedge clk);
        rst = 1'b1; bus.ce = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_i = '0;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    endtask

    // Reset, move CMP far away, then clear the match flag from cycle 0.
    // Afterwards CYCLE = 2 and STATUS = 0.
    task automatic quiet_reset();
        hard_reset();
        wr(A_CMP, 32'hFFFF_0000);
        wr(A_ST, 32'h7);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; bus.ce = 1'b1; bus.we = 1'b0; bus.addr = A_CMP; bus.data_i = '0;
        #1 total++;
        if (bus.data_o !== 32'h0) begin bad++; $display("FAIL rst_data_o got %h want %h", bus.data_o, 32'h0); end
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        rdw(A_CYC); total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL rst_cycle got %h want %h", rd, 32'h0); end
        rdw(A_CMP); total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL rst_cmp got %h want %h", rd, 32'h0); end
        // CYCLE==CMP==0 in the first cycle after reset sets the match flag
        rdw(A_ST); total++;
        if (rd !== 32'h1) begin bad++; $display("FAIL rst_status got %h want %h", rd, 32'h1); end
        rdw(A_ACC); total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL rst_access got %h want %h", rd, 32'h0); end
        rdw(A_CYC); total++;
        if (rd !== 32'h4) begin bad++; $display("FAIL cycle_count got %h want %h", rd, 32'h4); end
    endtask

    task automatic test_write_read();
        quiet_reset();
        wr(32'h10, 32'hDEAD_BEEF);
        rdw(32'h10); total++;
        if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_rd got %h want %h", rd, 32'hDEAD_BEEF); end
        rdw(A_ACC); total++;
        if (rd !== 32'h2) begin bad++; $display("FAIL wr_rd_access got %h want %h", rd, 32'h2); end
        wr(32'hFFC, 32'h5A5A_A5A5);
        rdw(32'hFFC); total++;
        if (rd !== 32'h5A5A_A5A5) begin bad++; $display("FAIL last_word got %h want %h", rd, 32'h5A5A_A5A5); end
        rdw(A_ACC); total++;
        if (rd !== 32'h4) begin bad++; $display("FAIL last_word_access got %h want %h", rd, 32'h4); end
    endtask

    task automatic test_misaligned();
        wr(32'h12, 32'h1234);
        rdw(A_ST); total++;
        if (rd !== 32'h4) begin bad++; $display("FAIL mis_status got %h want %h", rd, 32'h4); end
        rdw(A_ACC); total++;
        if (rd !== 32'h4) begin bad++; $display("FAIL mis_access got %h want %h", rd, 32'h4); end
        rdw(32'h11); total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL mis_rdata got %h want %h", rd, 32'h0); end
        rdw(32'h10); total++;
        if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mis_word4 got %h want %h", rd, 32'hDEAD_BEEF); end
        wr(A_ST, 32'h4);
        rdw(A_ST); total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL mis_w1c got %h want %h", rd, 32'h0); end
    endtask

    task automatic test_bad_addr();
        rdw(32'h2000_0000); total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL bad_rdata got %h want %h", rd, 32'h0); end
        rdw(A_ST); total++;
        if (rd !== 32'h2) begin bad++; $display("FAIL bad_status got %h want %h", rd, 32'h2); end
        rdw(32'h1000); total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL ram_end_rdata got %h want %h", rd, 32'h0); end
        wr(BASE + 32'h10, 32'h5);
        rdw(A_ACC); total++;
        if (rd !== 32'h5) begin bad++; $display("FAIL bad_access got %h want %h", rd, 32'h5); end
        wr(A_ST, 32'h2);
        rdw(A_ST); total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL bad_w1c got %h want %h", rd, 32'h0); end
    endtask

    task automatic test_set_wins();
        quiet_reset();
        rdw(A_CYC); total++;                      // cycle 2
        if (rd !== 32'h2) begin bad++; $display("FAIL sw_cycle got %h want %h", rd, 32'h2); end
        wr(A_CMP, 32'd6);                         // cycle 3
        rdw(32'h10);                              // cycle 4
        rdw(32'h10);                              // cycle 5
        wr(A_ST, 32'h1);                          // cycle 6: match and W1C together
        rdw(A_ST); total++;
        if (rd !== 32'h1) begin bad++; $display("FAIL set_wins got %h want %h", rd, 32'h1); end
        wr(A_ST, 32'h1);
        rdw(A_ST); total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL match_w1c got %h want %h", rd, 32'h0); end
    endtask

    task automatic test_match();
        bit found;
        hard_reset();
        wr(A_CMP, 32'd20);                        // cycle 0
        wr(A_ST, 32'h1);                          // cycle 1
        rdw(A_ST); total++;                       // cycle 2
        if (rd !== 32'h0) begin bad++; $display("FAIL match_early got %h want %h", rd, 32'h0); end
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            rdw(A_CYC);
            if (rd == 32'd20) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL match_reach got %0d want %0d", 0, 1); end
        rdw(A_ST); total++;                       // cycle 21
        if (rd !== 32'h1) begin bad++; $display("FAIL match_set got %h want %h", rd, 32'h1); end
        rdw(A_CYC); total++;                      // cycle 22
        if (rd !== 32'd22) begin bad++; $display("FAIL match_after got %h want %h", rd, 32'd22); end
    endtask

    task automatic test_wrap_sat();
        quiet_reset();
        @(negedge clk);
        force dut.cycle_q = 32'hFFFF_FFFF;
        bus.ce = 1'b1; bus.we = 1'b0; bus.addr = A_CYC; bus.data_i = '0;
        #1 total++;
        if (bus.data_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_pre got %h want %h", bus.data_o, 32'hFFFF_FFFF); end
        release dut.cycle_q;
        rdw(A_CYC); total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL wrap got %h want %h", rd, 32'h0); end
        @(negedge clk);
        force dut.access_q = 32'hFFFF_FFFF;
        bus.ce = 1'b1; bus.we = 1'b0; bus.addr = A_ACC;
        #1 total++;
        if (bus.data_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_pre got %h want %h", bus.data_o, 32'hFFFF_FFFF); end
        release dut.access_q;
        rdw(32'h10);
        rdw(A_ACC); total++;
        if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL saturate got %h want %h", rd, 32'hFFFF_FFFF); end
    endtask

    task automatic test_mid_reset();
        wr(32'h14, 32'h1111_1111);
        wr(A_CMP, 32'h55);
        @(negedge clk);
        rst = 1'b1; bus.ce = 1'b1; bus.we = 1'b1; bus.addr = 32'h14; bus.data_i = 32'h2222_2222;
        @(posedge clk); #1 rst = 1'b0; bus.ce = 1'b0;
        rdw(A_ACC); total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL mr_access got %h want %h", rd, 32'h0); end
        rdw(A_CMP); total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL mr_cmp got %h want %h", rd, 32'h0); end
        rdw(A_CYC); total++;
        if (rd !== 32'h2) begin bad++; $display("FAIL mr_cycle got %h want %h", rd, 32'h2); end
        rdw(32'h14); total++;
        if (rd !== 32'h1111_1111) begin bad++; $display("FAIL mr_target got %h want %h", rd, 32'h1111_1111); end
        rdw(32'h10); total++;
        if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mr_intact got %h want %h", rd, 32'hDEAD_BEEF); end
    endtask

    initial begin
        bus.ce = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_i = '0;
        test_reset();
        test_write_read();
        test_misaligned();
        test_bad_addr();
        test_set_wins();
        test_match();
        test_wrap_sat();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
